// File: rtl/alu_decode_unit.sv
// -----------------------------------------------------------------------------
// alu_decode_unit
// Execute stage of the 16-bit processor. The instruction word is sliced into
// its fields combinationally so the external register-file muxes can return
// r1/r2 in the same cycle. The selected ALU operation is then executed and
// registered together with a one-hot destination strobe. A 4-bit flag
// register {Z,N,C,V} drives conditional execution.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset, highest priority
//   inst_valid  in   inst/r1/r2 valid this cycle
//   inst[15:0]  in   instruction word {cond,op,dest,src1,src2,x}
//   r1, r2      in   operands returned by the external register muxes
//   cond        out  inst[15:14]
//   op_code     out  inst[13:10]
//   dest_reg    out  inst[9:7]
//   src_reg1    out  inst[6:4]
//   src_reg2    out  inst[3:1]
//   shift       out  inst[6:0] immediate / shift amount
//   alu_result  out  registered result
//   dest_onehot out  registered one-hot write select (bit n = register n)
//   wr_en       out  registered one-cycle write strobe
//   flags       out  registered {Z,N,C,V}
// -----------------------------------------------------------------------------
module alu_decode_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    input  logic [15:0] inst,
    input  logic [15:0] r1,
    input  logic [15:0] r2,
    output logic [1:0]  cond,
    output logic [3:0]  op_code,
    output logic [2:0]  dest_reg,
    output logic [2:0]  src_reg1,
    output logic [2:0]  src_reg2,
    output logic [6:0]  shift,
    output logic [15:0] alu_result,
    output logic [7:0]  dest_onehot,
    output logic        wr_en,
    output logic [3:0]  flags
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_MOV = 4'b0110;
    localparam logic [3:0] OP_LSL = 4'b0111;
    localparam logic [3:0] OP_LSR = 4'b1000;
    localparam logic [3:0] OP_LDI = 4'b1001;
    localparam logic [3:0] OP_INC = 4'b1010;
    localparam logic [3:0] OP_DEC = 4'b1011;
    localparam logic [3:0] OP_ASR = 4'b1100;
    localparam logic [3:0] OP_ROL = 4'b1101;
    localparam logic [3:0] OP_CMP = 4'b1110;
    localparam logic [3:0] OP_NOP = 4'b1111;

    // Flag bit positions inside {Z,N,C,V}
    localparam int FZ = 3;
    localparam int FN = 2;
    localparam int FC = 1;
    localparam int FV = 0;

    function automatic logic [7:0] decoder3by8(input logic [2:0] sel);
        decoder3by8 = 8'b0000_0001 << sel;
    endfunction

    logic [15:0] alu_result_r;
    logic [7:0]  dest_onehot_r;
    logic        wr_en_r;
    logic [3:0]  flags_r;

    logic [3:0]  sh_s;
    logic [15:0] b_s;
    logic [16:0] sum_s;
    logic [16:0] diff_s;
    logic [15:0] res_s;
    logic        c_s;
    logic        v_s;
    logic        writes_s;
    logic        cond_true_s;
    logic        exec_s;
    logic [3:0]  flags_next_s;

    assign cond     = inst[15:14];
    assign op_code  = inst[13:10];
    assign dest_reg = inst[9:7];
    assign src_reg1 = inst[6:4];
    assign src_reg2 = inst[3:1];
    assign shift    = inst[6:0];
    assign sh_s     = inst[3:0];

    assign alu_result  = alu_result_r;
    assign dest_onehot = dest_onehot_r;
    assign wr_en       = wr_en_r;
    assign flags       = flags_r;

    // Condition evaluation against the flags held before this edge
    always_comb begin
        cond_true_s = 1'b0;
        case (cond)
            2'b00:   cond_true_s = 1'b1;
            2'b01:   cond_true_s = flags_r[FZ];
            2'b10:   cond_true_s = ~flags_r[FZ];
            2'b11:   cond_true_s = flags_r[FC];
            default: cond_true_s = 1'b0;
        endcase
        exec_s = inst_valid & cond_true_s;
    end

    // ALU datapath: result, carry/overflow and whether the op writes back
    always_comb begin
        // INC/DEC reuse the adder/subtractor with a constant second operand
        if ((op_code == OP_INC) || (op_code == OP_DEC)) begin
            b_s = 16'd1;
        end else begin
            b_s = r2;
        end
        sum_s    = {1'b0, r1} + {1'b0, b_s};
        diff_s   = {1'b0, r1} - {1'b0, b_s};
        res_s    = 16'h0000;
        c_s      = flags_r[FC];
        v_s      = flags_r[FV];
        writes_s = 1'b1;
        case (op_code)
            OP_ADD, OP_INC: begin
                res_s = sum_s[15:0];
                c_s   = sum_s[16];
                v_s   = (r1[15] == b_s[15]) && (sum_s[15] != r1[15]);
            end
            OP_SUB, OP_DEC, OP_CMP: begin
                res_s = diff_s[15:0];
                // Carry means "no borrow", i.e. unsigned r1 >= operand
                c_s   = ~diff_s[16];
                v_s   = (r1[15] != b_s[15]) && (diff_s[15] != r1[15]);
                writes_s = (op_code != OP_CMP);
            end
            OP_AND: res_s = r1 & r2;
            OP_OR:  res_s = r1 | r2;
            OP_XOR: res_s = r1 ^ r2;
            OP_NOT: res_s = ~r1;
            OP_MOV: res_s = r1;
            OP_LSL: res_s = r1 << sh_s;
            OP_LSR: res_s = r1 >> sh_s;
            OP_LDI: res_s = {9'b0_0000_0000, shift};
            OP_ASR: res_s = $signed(r1) >>> sh_s;
            // r1 >> 16 is zero, so a rotate by 0 degenerates to r1
            OP_ROL: res_s = (r1 << sh_s) | (r1 >> (5'd16 - {1'b0, sh_s}));
            OP_NOP: writes_s = 1'b0;
            default: begin
                res_s    = 16'h0000;
                writes_s = 1'b0;
            end
        endcase
    end

    // Next-flag selection: NOP leaves everything, others refresh Z/N
    always_comb begin
        flags_next_s = flags_r;
        if (op_code != OP_NOP) begin
            flags_next_s[FZ] = (res_s == 16'h0000);
            flags_next_s[FN] = res_s[15];
            flags_next_s[FC] = c_s;
            flags_next_s[FV] = v_s;
        end else begin
            flags_next_s = flags_r;
        end
    end

    // Registered result, write strobe and flag state
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result_r  <= 16'h0000;
            dest_onehot_r <= 8'h00;
            wr_en_r       <= 1'b0;
            flags_r       <= 4'h0;
        end else if (exec_s) begin
            flags_r <= flags_next_s;
            if (writes_s) begin
                alu_result_r  <= res_s;
                dest_onehot_r <= decoder3by8(dest_reg);
                wr_en_r       <= 1'b1;
            end else begin
                dest_onehot_r <= 8'h00;
                wr_en_r       <= 1'b0;
            end
        end else begin
            dest_onehot_r <= 8'h00;
            wr_en_r       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_decode_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_decode_unit
// Directed self-checking bench for alu_decode_unit. Inputs are driven 1 time
// unit after a rising edge; registered outputs are checked 1 unit after the
// following rising edge, combinational field outputs before that edge.
// -----------------------------------------------------------------------------
module tb_alu_decode_unit;

    logic        clk;
    logic        rst;
    logic        inst_valid;
    logic [15:0] inst;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [1:0]  cond;
    logic [3:0]  op_code;
    logic [2:0]  dest_reg;
    logic [2:0]  src_reg1;
    logic [2:0]  src_reg2;
    logic [6:0]  shift;
    logic [15:0] alu_result;
    logic [7:0]  dest_onehot;
    logic        wr_en;
    logic [3:0]  flags;

    int checks;
    int errors;

    alu_decode_unit dut (
        .clk         (clk),
        .rst         (rst),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .r1          (r1),
        .r2          (r2),
        .cond        (cond),
        .op_code     (op_code),
        .dest_reg    (dest_reg),
        .src_reg1    (src_reg1),
        .src_reg2    (src_reg2),
        .shift       (shift),
        .alu_result  (alu_result),
        .dest_onehot (dest_onehot),
        .wr_en       (wr_en),
        .flags       (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {cond, op, dest, src1, src2, 0}
    function automatic logic [15:0] mk(input logic [1:0] c, input logic [3:0] op,
                                       input logic [2:0] d, input logic [2:0] s1,
                                       input logic [2:0] s2);
        mk = {c, op, d, s1, s2, 1'b0};
    endfunction

    // {cond, op, dest, imm7}
    function automatic logic [15:0] mki(input logic [1:0] c, input logic [3:0] op,
                                        input logic [2:0] d, input logic [6:0] imm);
        mki = {c, op, d, imm};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    // Drive one instruction, then advance past the capturing edge
    task automatic step(input logic v, input logic [15:0] i,
                        input logic [15:0] a, input logic [15:0] b);
        inst_valid = v;
        inst       = i;
        r1         = a;
        r2         = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [15:0] res,
                           input logic [7:0] oh, input logic we, input logic [3:0] fl);
        chk({tag, "_result"}, alu_result, res);
        chk({tag, "_onehot"}, {8'h00, dest_onehot}, {8'h00, oh});
        chk({tag, "_wr_en"}, {15'h0000, wr_en}, {15'h0000, we});
        chk({tag, "_flags"}, {12'h000, flags}, {12'h000, fl});
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        inst_valid = 1'b1;
        inst       = 16'h0194;
        r1         = 16'd5;
        r2         = 16'd7;

        // Reset held two cycles with a valid instruction present
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk_out("reset", 16'h0000, 8'h00, 1'b0, 4'b0000);
        rst = 1'b0;

        // ADD 5+7 into r3; fields visible before the edge
        inst = 16'h0194;
        #1;
        chk("f_cond", {14'h0, cond}, 16'h0000);
        chk("f_op", {12'h0, op_code}, 16'h0000);
        chk("f_dest", {13'h0, dest_reg}, 16'h0003);
        chk("f_src1", {13'h0, src_reg1}, 16'h0001);
        chk("f_src2", {13'h0, src_reg2}, 16'h0002);
        chk("f_shift", {9'h0, shift}, 16'h0014);
        step(1'b1, 16'h0194, 16'd5, 16'd7);
        chk_out("add", 16'd12, 8'b0000_1000, 1'b1, 4'b0000);

        // SUB equal operands -> zero, Z=1 C=1
        step(1'b1, mk(2'b00, 4'b0001, 3'd1, 3'd1, 3'd2), 16'h1234, 16'h1234);
        chk_out("sub0", 16'h0000, 8'b0000_0010, 1'b1, 4'b1010);

        // cond 10 (Z=0) is false while Z=1
        step(1'b1, mk(2'b10, 4'b0000, 3'd2, 3'd1, 3'd1), 16'd1, 16'd1);
        chk_out("c10_skip", 16'h0000, 8'h00, 1'b0, 4'b1010);

        // cond 01 (Z=1) true: MOV into r7; Z/N refreshed, C/V kept
        step(1'b1, mk(2'b01, 4'b0110, 3'd7, 3'd4, 3'd0), 16'hBEEF, 16'h0000);
        chk_out("c01_mov", 16'hBEEF, 8'b1000_0000, 1'b1, 4'b0110);

        // cond 01 now false (Z=0)
        step(1'b1, mk(2'b01, 4'b0000, 3'd2, 3'd1, 3'd1), 16'd1, 16'd1);
        chk_out("c01_skip", 16'hBEEF, 8'h00, 1'b0, 4'b0110);

        // LDI 0x55 into r0
        step(1'b1, mki(2'b00, 4'b1001, 3'd0, 7'h55), 16'hAAAA, 16'hAAAA);
        chk_out("ldi", 16'h0055, 8'b0000_0001, 1'b1, 4'b0010);

        // LSL 0x0F0F by 4
        step(1'b1, mki(2'b00, 4'b0111, 3'd5, 7'h04), 16'h0F0F, 16'h0000);
        chk_out("lsl", 16'hF0F0, 8'b0010_0000, 1'b1, 4'b0110);

        // ASR 0x8000 by 15
        step(1'b1, mki(2'b00, 4'b1100, 3'd6, 7'h0F), 16'h8000, 16'h0000);
        chk_out("asr", 16'hFFFF, 8'b0100_0000, 1'b1, 4'b0110);

        // ROL 0x8001 by 1
        step(1'b1, mki(2'b00, 4'b1101, 3'd4, 7'h01), 16'h8001, 16'h0000);
        chk_out("rol", 16'h0003, 8'b0001_0000, 1'b1, 4'b0010);

        // LSR 0x8000 by 3 is logical
        step(1'b1, mki(2'b00, 4'b1000, 3'd4, 7'h03), 16'h8000, 16'h0000);
        chk_out("lsr", 16'h1000, 8'b0001_0000, 1'b1, 4'b0010);

        // ADD with carry-out to zero
        step(1'b1, mk(2'b00, 4'b0000, 3'd1, 3'd1, 3'd2), 16'hFFFF, 16'h0001);
        chk_out("add_c", 16'h0000, 8'b0000_0010, 1'b1, 4'b1010);

        // cond 11 (C=1) true: XOR
        step(1'b1, mk(2'b11, 4'b0100, 3'd2, 3'd1, 3'd2), 16'hFF00, 16'h0FF0);
        chk_out("c11_xor", 16'hF0F0, 8'b0000_0100, 1'b1, 4'b0110);

        // ADD signed overflow
        step(1'b1, mk(2'b00, 4'b0000, 3'd1, 3'd1, 3'd2), 16'h7FFF, 16'h0001);
        chk_out("add_v", 16'h8000, 8'b0000_0010, 1'b1, 4'b0101);

        // CMP 3,5: flags only, borrow -> C=0
        step(1'b1, mk(2'b00, 4'b1110, 3'd3, 3'd1, 3'd2), 16'd3, 16'd5);
        chk_out("cmp", 16'h8000, 8'h00, 1'b0, 4'b0100);

        // cond 11 now false (C=0)
        step(1'b1, mk(2'b11, 4'b0110, 3'd3, 3'd1, 3'd2), 16'h1111, 16'd5);
        chk_out("c11_skip", 16'h8000, 8'h00, 1'b0, 4'b0100);

        // Gap: inst_valid low
        step(1'b0, mk(2'b00, 4'b0000, 3'd3, 3'd1, 3'd2), 16'd1, 16'd1);
        chk_out("gap", 16'h8000, 8'h00, 1'b0, 4'b0100);

        // NOP
        step(1'b1, mk(2'b00, 4'b1111, 3'd3, 3'd1, 3'd2), 16'd0, 16'd0);
        chk_out("nop", 16'h8000, 8'h00, 1'b0, 4'b0100);

        // INC 0xFFFF wraps to zero with carry
        step(1'b1, mk(2'b00, 4'b1010, 3'd0, 3'd1, 3'd0), 16'hFFFF, 16'h1234);
        chk_out("inc", 16'h0000, 8'b0000_0001, 1'b1, 4'b1010);

        // DEC 0x8000 -> 0x7FFF, no borrow, signed overflow
        step(1'b1, mk(2'b00, 4'b1011, 3'd0, 3'd1, 3'd0), 16'h8000, 16'h1234);
        chk_out("dec", 16'h7FFF, 8'b0000_0001, 1'b1, 4'b0011);

        // NOT then AND/OR, C/V retained
        step(1'b1, mk(2'b00, 4'b0101, 3'd0, 3'd1, 3'd0), 16'h00FF, 16'h0000);
        chk_out("not", 16'hFF00, 8'b0000_0001, 1'b1, 4'b0111);
        step(1'b1, mk(2'b00, 4'b0010, 3'd0, 3'd1, 3'd2), 16'hF0F0, 16'h0F0F);
        chk_out("and", 16'h0000, 8'b0000_0001, 1'b1, 4'b1011);
        step(1'b1, mk(2'b00, 4'b0011, 3'd0, 3'd1, 3'd2), 16'h0A00, 16'h00A0);
        chk_out("or", 16'h0AA0, 8'b0000_0001, 1'b1, 4'b0011);

        // Every destination register decodes to its own one-hot bit
        for (int d = 0; d < 8; d++) begin
            logic [7:0]  exp_oh;
            logic [15:0] val;
            exp_oh = 8'b0000_0001 << d;
            val    = 16'h0100 + 16'(d);
            step(1'b1, mk(2'b00, 4'b0110, 3'(d), 3'd1, 3'd0), val, 16'h0000);
            chk_out("dest", val, exp_oh, 1'b1, 4'b0011);
        end

        // Reset wins over a valid instruction
        rst = 1'b1;
        step(1'b1, mk(2'b00, 4'b0110, 3'd2, 3'd1, 3'd0), 16'h5555, 16'h0000);
        chk_out("rst_win", 16'h0000, 8'h00, 1'b0, 4'b0000);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
